// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two instruction buffer with push/pop/flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage has no reset; entries are only observed once count says they are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem request FSM and decode-facing instruction buffer (option: FETCH_MISALIGN_CHECK_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = FETCH_XLEN,
  parameter int              ILEN         = FETCH_ILEN,
  parameter int              IBUF_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t         state;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pend_pc;
  logic [XLEN-1:0]      target;
  logic [CW-1:0]        fifo_count;
  logic [XLEN+ILEN-1:0] head;
  logic                 outstanding;
  logic                 can_issue;
  logic                 req_fire;
  logic                 push;
  logic                 pop;
  logic                 misaligned;

  assign target = {redirect_target[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign misaligned  = |redirect_target[1:0];
  assign fetch_fault = fault_q;
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^redirect_target[1:0];
  assign misaligned        = 1'b0;
  assign fetch_fault       = 1'b0;
`endif

  // Issue only when a FIFO slot is guaranteed for the response; redirect cancels combinationally.
  assign outstanding    = (state == S_WAIT) || (state == S_DROP);
  assign can_issue      = (int'(fifo_count) + int'(outstanding)) < IBUF_DEPTH;
  assign imem_req_valid = (state == S_REQ) && can_issue && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push        = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_pc    = head[XLEN+ILEN-1:ILEN];
  assign instr       = head[ILEN-1:0];

  fetch_fifo #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pend_pc, imem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_VECTOR;
      pend_pc <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else if (state == S_HALT) begin
      state <= S_HALT;
    end else if (redirect_valid) begin
      pc <= target;
      if (misaligned) begin
        state <= S_HALT;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_q <= 1'b1;
`endif
      end else if (outstanding && !imem_rsp_valid) begin
        state <= S_DROP;
      end else begin
        // A response landing in the redirect cycle is stale and simply discarded.
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            pc      <= pc + XLEN'(PC_STEP);
            pend_pc <= pc;
            state   <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a PC-stream reference model
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (XLEN),
    .ILEN         (ILEN),
    .IBUF_DEPTH   (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: expected next fetch address, expected next delivered PC,
  // live buffered instructions, and the single memory slot.
  bit          outst;
  bit          stale;
  bit          halted;
  logic [31:0] slot_addr;
  int          due;
  int          live;
  int          pops;
  logic [31:0] exp_req;
  logic [31:0] exp_pop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic step(input bit redir, input logic [31:0] tgt, input bit rq_rdy,
                      input bit dec_rdy, input int lat);
    bit exp_rv;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid  = redir;
    redirect_target = tgt;
    imem_req_ready  = rq_rdy;
    instr_ready     = dec_rdy;
    if (outst && cyc >= due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(slot_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    exp_rv = !halted && !redir && !outst && (live < DEPTH);
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req);
    check_eq("instr_valid", instr_valid, live > 0);
    if (instr_valid) begin
      check_eq("instr_pc", instr_pc, exp_pop);
      check_eq("instr", instr, memf(exp_pop));
    end
    check_eq("fetch_fault", fetch_fault, halted);
    if (!redir && dec_rdy && live > 0) begin
      exp_pop += 32'd4;
      live--;
      pops++;
    end
    if (imem_rsp_valid) begin
      if (!stale && !redir) live++;
      outst = 1'b0;
    end
    if (imem_req_valid && rq_rdy) begin
      outst     = 1'b1;
      stale     = 1'b0;
      slot_addr = exp_req;
      due       = cyc + lat;
      exp_req  += 32'd4;
    end
    if (redir && !halted) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
      exp_req = {tgt[31:2], 2'b00};
      exp_pop = exp_req;
      live    = 0;
      stale   = 1'b1;
    end
  endtask

  task automatic do_reset();
    bit late;
    late = outst;
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    imem_rsp_valid = 1'b0;
    #2;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_fault", fetch_fault, 0);
    check_eq("rst_req_addr", imem_req_addr, RV);
    outst   = 1'b0;
    stale   = 1'b0;
    halted  = 1'b0;
    live    = 0;
    exp_req = RV;
    exp_pop = RV;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_rsp_valid = late;
    imem_rsp_data  = 32'hDEAD_BEEF;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    @(negedge clk);
    check_eq("idle_req_valid", imem_req_valid, 0);
    check_eq("idle_instr_valid", instr_valid, 0);
  endtask

  initial begin
    bit          hit;
    bit          r;
    logic [31:0] t;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    instr_ready     = 1'b0;
    outst = 1'b0; stale = 1'b0; halted = 1'b0;
    live = 0; pops = 0; due = 0; slot_addr = '0;
    exp_req = RV; exp_pop = RV;

    do_reset();
    pops = 0;
    repeat (12) step(0, '0, 1, 1, 1);
    check_eq("basic_progress", pops >= 4, 1);

    repeat (10) step(0, '0, 1, 0, 1);
    check_eq("stall_full_blocks_req", imem_req_valid, 0);
    check_eq("stall_buffer_full", instr_valid, 1);
    repeat (10) step(0, '0, 1, 1, 1);

    do_reset();
    step(0, '0, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 1);
    check_eq("hold_addr", imem_req_addr, 32'h4);
    check_eq("hold_valid", imem_req_valid, 1);
    repeat (6) step(0, '0, 1, 1, 1);

    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (outst && (cyc + 1 < due)) begin
        step(1, 32'h100, 1, 1, 3);
        hit = 1'b1;
      end else begin
        step(0, '0, 1, 1, 3);
      end
    end
    check_eq("redir_mid_hit", hit, 1);
    pops = 0;
    repeat (15) step(0, '0, 1, 1, 3);
    check_eq("redir_mid_progress", pops >= 2, 1);

    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (outst && (cyc + 1 >= due)) begin
        step(1, 32'h200, 1, 1, 2);
        hit = 1'b1;
      end else begin
        step(0, '0, 1, 1, 2);
      end
    end
    check_eq("redir_same_hit", hit, 1);
    repeat (12) step(0, '0, 1, 1, 2);

    step(1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (14) step(0, '0, 1, 1, 1);

    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(15) == 0);
      t = 32'($urandom_range(1023)) << 2;
      step(r, t, $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(4, 1));
      if (i == 700) do_reset();
    end

    do_reset();
    repeat (6) step(0, '0, 1, 1, 1);
    step(1, 32'h102, 1, 1, 1);
    pops = 0;
    repeat (12) step(0, '0, 1, 1, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("misalign_fault", fetch_fault, 1);
    check_eq("misalign_no_fetch", pops, 0);
`else
    check_eq("misalign_progress", pops >= 3, 1);
`endif
    do_reset();
    repeat (4) step(0, '0, 1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
